// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// Holds the buffered write-back entry and the one-hot register enable decode.
package regfile_pkg;

   localparam int unsigned N          = 32;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned NUM_REGS   = 1 << ADDR_W;
   localparam int unsigned STARVE_MAX = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [N-1:0]      wd;
   } wb_entry_t;

   // x0 is hardwired, so its enable bit is never produced.
   function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] idx);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (idx != '0) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small FIFO of write-back entries for long-latency results.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = din;
         wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; entries are only read once the pointers say so.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: core results first, buffered long-latency
// results drain into free slots, with a pending-destination scoreboard.
module regfile_write_arbiter #(
   parameter int unsigned N          = regfile_pkg::N,
   parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = regfile_pkg::STARVE_MAX
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     core_we,
   input  logic [ADDR_W-1:0]        core_rd,
   input  logic [N-1:0]             core_wd,
   input  logic                     lu_valid,
   output logic                     lu_ready,
   input  logic [ADDR_W-1:0]        lu_rd,
   input  logic [N-1:0]             lu_wd,
   input  logic                     issue_valid,
   input  logic [ADDR_W-1:0]        issue_rd,
   input  logic [ADDR_W-1:0]        rs1,
   input  logic [ADDR_W-1:0]        rs2,
   output logic                     busy_rs1,
   output logic                     busy_rs2,
   output logic                     stall_req,
   output logic                     hazard_err,
   output logic [(1<<ADDR_W)-1:0]   wr_en,
   output logic [N-1:0]             wr_data
);

   import regfile_pkg::wb_entry_t;
   import regfile_pkg::onehot_dec;

   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam int unsigned CNT_W    = $clog2(STARVE_MAX + 1);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    starve_q, starve_d;
   logic                hazard_q, hazard_d;

   logic      fifo_full, fifo_empty, head_valid;
   logic      push, pop, core_eff;
   wb_entry_t head, lu_entry;

   assign lu_entry = '{rd: lu_rd, wd: lu_wd};
   assign lu_ready = !fifo_full && !reset;
   assign push     = lu_valid && lu_ready;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (lu_entry),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   assign head_valid = !fifo_empty;
   assign stall_req  = !reset && head_valid && (starve_q == CNT_W'(STARVE_MAX));
   assign core_eff   = !reset && core_we && (core_rd != '0) && !stall_req;
   assign pop        = !reset && !core_eff && head_valid;

   assign busy_rs1   = (rs1 != '0) && pending_q[rs1];
   assign busy_rs2   = (rs2 != '0) && pending_q[rs2];
   assign hazard_err = hazard_q;

   // Write-port mux: core slot, else FIFO head, else idle.
   always_comb begin
      wr_en   = '0;
      wr_data = '0;
      if (core_eff) begin
         wr_en   = onehot_dec(core_rd);
         wr_data = core_wd;
      end else if (pop) begin
         wr_en   = onehot_dec(head.rd);
         wr_data = head.wd;
      end
   end

   // Scoreboard, starvation counter and sticky hazard flag.
   always_comb begin
      pending_d = pending_q;
      starve_d  = starve_q;
      hazard_d  = hazard_q;

      if (pop) pending_d[head.rd] = 1'b0;
      if (issue_valid) pending_d[issue_rd] = 1'b1;
      pending_d[0] = 1'b0;

      if (fifo_empty || pop) starve_d = '0;
      else if (core_eff)     starve_d = starve_q + CNT_W'(1);

      if (core_eff && pending_q[core_rd]) hazard_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         starve_q  <= '0;
         hazard_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         hazard_q  <= hazard_d;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset;
   logic        core_we;
   logic [4:0]  core_rd;
   logic [31:0] core_wd;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_wd;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  rs1, rs2;
   logic        busy_rs1, busy_rs2;
   logic        stall_req;
   logic        hazard_err;
   logic [31:0] wr_en;
   logic [31:0] wr_data;

   int errors = 0;
   int checks = 0;

   regfile_write_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .core_we     (core_we),
      .core_rd     (core_rd),
      .core_wd     (core_wd),
      .lu_valid    (lu_valid),
      .lu_ready    (lu_ready),
      .lu_rd       (lu_rd),
      .lu_wd       (lu_wd),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .busy_rs1    (busy_rs1),
      .busy_rs2    (busy_rs2),
      .stall_req   (stall_req),
      .hazard_err  (hazard_err),
      .wr_en       (wr_en),
      .wr_data     (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; core_we = 1'b0; core_rd = '0; core_wd = '0;
      lu_valid = 1'b0; lu_rd = '0; lu_wd = '0;
      issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;

      // Reset state
      tick();
      tick();
      #1;
      check("rst_wr_en", 64'(wr_en), 64'h0);
      check("rst_lu_ready", 64'(lu_ready), 64'h0);
      check("rst_stall", 64'(stall_req), 64'h0);
      check("rst_hazard", 64'(hazard_err), 64'h0);

      reset = 1'b0; rs1 = 5'd7; rs2 = 5'd9;
      #1;
      check("rel_lu_ready", 64'(lu_ready), 64'h1);
      check("rel_busy1", 64'(busy_rs1), 64'h0);
      check("rel_busy2", 64'(busy_rs2), 64'h0);

      // Core write x5, then write to x0
      core_we = 1'b1; core_rd = 5'd5; core_wd = 32'hDEADBEEF;
      #1;
      check("core_x5_en", 64'(wr_en), 64'h20);
      check("core_x5_data", 64'(wr_data), 64'hDEADBEEF);
      tick();
      core_rd = 5'd0; core_wd = 32'h5555;
      #1;
      check("core_x0_en", 64'(wr_en), 64'h0);
      check("core_x0_data", 64'(wr_data), 64'h0);
      tick();
      core_we = 1'b0;

      // Issue x7, long-latency result arrives next cycle
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd7; lu_wd = 32'h1234;
      #1;
      check("x7_busy_pre", 64'(busy_rs1), 64'h1);
      check("x7_ready", 64'(lu_ready), 64'h1);
      tick();
      lu_valid = 1'b0;
      #1;
      check("x7_drain_en", 64'(wr_en), 64'h80);
      check("x7_drain_data", 64'(wr_data), 64'h1234);
      check("x7_busy_e0", 64'(busy_rs1), 64'h1);
      tick();
      #1;
      check("x7_busy_e1", 64'(busy_rs1), 64'h0);
      check("x7_idle_en", 64'(wr_en), 64'h0);

      // Starvation: core writes x1 every cycle while x3, x4 results queue
      core_we = 1'b1; core_rd = 5'd1; core_wd = 32'h11;
      lu_valid = 1'b1; lu_rd = 5'd3; lu_wd = 32'hAAAA;
      #1;
      check("stv_a_en", 64'(wr_en), 64'h2);
      tick();
      lu_rd = 5'd4; lu_wd = 32'hBBBB; core_wd = 32'h12;
      #1;
      check("stv_b_ready", 64'(lu_ready), 64'h1);
      check("stv_b_stall", 64'(stall_req), 64'h0);
      tick();
      lu_rd = 5'd6; lu_wd = 32'hCCCC; core_wd = 32'h13;
      #1;
      check("stv_c_full", 64'(lu_ready), 64'h0);
      check("stv_c_en", 64'(wr_en), 64'h2);
      tick();
      core_wd = 32'h14;
      #1;
      check("stv_d_stall", 64'(stall_req), 64'h0);
      tick();
      core_wd = 32'h15;
      #1;
      check("stv_e_stall", 64'(stall_req), 64'h0);
      check("stv_e_data", 64'(wr_data), 64'h15);
      tick();
      core_wd = 32'h16;
      #1;
      check("stv_f_stall", 64'(stall_req), 64'h1);
      check("stv_f_en", 64'(wr_en), 64'h8);
      check("stv_f_data", 64'(wr_data), 64'hAAAA);
      check("stv_f_ready", 64'(lu_ready), 64'h0);
      tick();
      lu_valid = 1'b0; core_wd = 32'h17;
      #1;
      check("stv_g_stall", 64'(stall_req), 64'h0);
      check("stv_g_en", 64'(wr_en), 64'h2);
      check("stv_g_ready", 64'(lu_ready), 64'h1);
      tick();
      core_we = 1'b0;
      #1;
      check("stv_h_en", 64'(wr_en), 64'h10);
      check("stv_h_data", 64'(wr_data), 64'hBBBB);
      tick();
      #1;
      check("stv_i_empty", 64'(wr_en), 64'h0);

      // Same-cycle set and clear of pending[9]
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick();
      issue_valid = 1'b0;
      lu_valid = 1'b1; lu_rd = 5'd9; lu_wd = 32'h99;
      tick();
      lu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 5'd9;
      #1;
      check("x9_drain_en", 64'(wr_en), 64'h200);
      tick();
      issue_valid = 1'b0;
      #1;
      check("x9_still_busy", 64'(busy_rs2), 64'h1);
      check("x9_no_hazard", 64'(hazard_err), 64'h0);

      // Core write to pending x9 raises sticky hazard
      core_we = 1'b1; core_rd = 5'd9; core_wd = 32'h42;
      #1;
      check("hz_write_en", 64'(wr_en), 64'h200);
      tick();
      core_we = 1'b0;
      #1;
      check("hz_set", 64'(hazard_err), 64'h1);
      tick();
      #1;
      check("hz_hold", 64'(hazard_err), 64'h1);

      // Mid-operation reset
      reset = 1'b1; core_we = 1'b1; core_rd = 5'd2;
      #1;
      check("mrst_wr_en", 64'(wr_en), 64'h0);
      check("mrst_lu_ready", 64'(lu_ready), 64'h0);
      tick();
      reset = 1'b0; core_we = 1'b0;
      #1;
      check("mrst_hazard", 64'(hazard_err), 64'h0);
      check("mrst_busy2", 64'(busy_rs2), 64'h0);
      check("mrst_ready", 64'(lu_ready), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
